// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
    // Requester side
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        err;
    logic [31:0] rdata;
    // Memory side
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_rdata, mem_ready,
        output gnt0, gnt1, done0, done1, err, rdata,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_rdata, mem_ready,
        input  gnt0, gnt1, done0, done1, err, rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter with a 16-cycle access timeout.
// One access at a time: IDLE -> ACCESS (strobes held) -> RESP (done pulse).
module mem_arbiter (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state_q;
    logic        armed_q;
    logic        last_q;
    logic        owner_q;
    logic [3:0]  wait_q;
    logic        gnt0_q;
    logic        gnt1_q;
    logic        done0_q;
    logic        done1_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        any_req_d;
    logic        win_d;
    logic        sel_we_d;
    logic [31:0] sel_addr_d;
    logic [31:0] sel_wdata_d;

    // Round-robin winner and its request fields; on a tie the requester not granted last wins
    always_comb begin
        any_req_d   = bus.req0 | bus.req1;
        win_d       = bus.req1 & (~bus.req0 | ~last_q);
        sel_we_d    = win_d ? bus.we1    : bus.we0;
        sel_addr_d  = win_d ? bus.addr1  : bus.addr0;
        sel_wdata_d = win_d ? bus.wdata1 : bus.wdata0;
    end

    // Access FSM with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            wait_q      <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // armed_q holds off arbitration for the first edge after reset release
            armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (armed_q && any_req_d) begin
                        state_q     <= ACCESS;
                        owner_q     <= win_d;
                        last_q      <= win_d;
                        gnt0_q      <= ~win_d;
                        gnt1_q      <= win_d;
                        wait_q      <= '0;
                        mem_read_q  <= ~sel_we_d;
                        mem_write_q <= sel_we_d;
                        mem_addr_q  <= sel_addr_d;
                        mem_wdata_q <= sel_wdata_d;
                    end
                end
                ACCESS: begin
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                    if (bus.mem_ready || (wait_q == 4'hF)) begin
                        // A ready on the last allowed cycle still wins over the timeout
                        state_q     <= RESP;
                        done0_q     <= ~owner_q;
                        done1_q     <= owner_q;
                        err_q       <= ~bus.mem_ready;
                        rdata_q     <= (bus.mem_ready && mem_read_q) ? bus.mem_rdata : '0;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                RESP: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read, contention, timeout, reset abort, withdrawal.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check the pairwise exclusions
    task automatic tick();
        @(negedge clk);
        chk("excl", {29'd0, bus.gnt0 & bus.gnt1, bus.done0 & bus.done1,
                     bus.mem_read & bus.mem_write}, 32'd0);
    endtask

    task automatic clear_inputs();
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    endtask

    initial begin
        int n;
        int g;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;

        clear_inputs();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        chk("rst_done_err", {29'd0, bus.err, bus.done1, bus.done0}, 32'd0);
        chk("rst_strobes", {30'd0, bus.mem_write, bus.mem_read}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        tick();
        tick();

        // Single read, ready on third ACCESS cycle; also first-grant delay after reset
        reset = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h100;
        tick();
        chk("arm_no_gnt", {31'd0, bus.gnt0}, 32'd0);
        tick();
        chk("rd_gnt0", {31'd0, bus.gnt0}, 32'd1);
        chk("rd_mem_read1", {31'd0, bus.mem_read}, 32'd1);
        chk("rd_mem_addr", bus.mem_addr, 32'h100);
        bus.req0 = 1'b0;
        tick();
        chk("rd_gnt0_pulse", {31'd0, bus.gnt0}, 32'd0);
        chk("rd_mem_read2", {31'd0, bus.mem_read}, 32'd1);
        tick();
        chk("rd_mem_read3", {31'd0, bus.mem_read}, 32'd1);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        tick();
        chk("rd_done0", {30'd0, bus.done1, bus.done0}, 32'd1);
        chk("rd_rdata", bus.rdata, 32'hCAFEF00D);
        chk("rd_err", {31'd0, bus.err}, 32'd0);
        chk("rd_strobe_off", {30'd0, bus.mem_write, bus.mem_read}, 32'd0);
        chk("rd_addr_off", bus.mem_addr, 32'd0);
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        tick();
        chk("rd_done_pulse", {30'd0, bus.done1, bus.done0}, 32'd0);
        chk("rd_rdata_hold", bus.rdata, 32'hCAFEF00D);

        // Contention: both write continuously, ready always high
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.we0 = 1'b1; bus.we1 = 1'b1;
        bus.addr0 = 32'hA0; bus.wdata0 = 32'h11110000;
        bus.addr1 = 32'hB0; bus.wdata1 = 32'h22220000;
        bus.mem_ready = 1'b1;
        tick();
        chk("ct_arm", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            g = i % 2;
            exp_addr  = (g == 0) ? 32'hA0 : 32'hB0;
            exp_wdata = (g == 0) ? 32'h11110000 : 32'h22220000;
            tick();
            chk("ct_gnt", {30'd0, bus.gnt1, bus.gnt0}, (g == 0) ? 32'd1 : 32'd2);
            chk("ct_write", {30'd0, bus.mem_write, bus.mem_read}, 32'd2);
            chk("ct_addr", bus.mem_addr, exp_addr);
            chk("ct_wdata", bus.mem_wdata, exp_wdata);
            tick();
            chk("ct_done", {30'd0, bus.done1, bus.done0}, (g == 0) ? 32'd1 : 32'd2);
            chk("ct_wr_rdata", bus.rdata, 32'd0);
            tick();
            chk("ct_idle", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
            if (i == 3) begin
                bus.req0 = 1'b0; bus.req1 = 1'b0; bus.mem_ready = 1'b0;
            end
        end

        // Timeout: requester 1 read, memory never ready
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h2000;
        tick();
        chk("to_gnt1", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
        chk("to_addr", bus.mem_addr, 32'h2000);
        bus.req1 = 1'b0;
        n = 1;
        for (int i = 0; i < 40 && !bus.done1; i++) begin
            tick();
            if (bus.mem_read) n++;
        end
        chk("to_done1", {30'd0, bus.done1, bus.done0}, 32'd2);
        chk("to_read_cycles", n, 32'd16);
        chk("to_err", {31'd0, bus.err}, 32'd1);
        chk("to_rdata", bus.rdata, 32'd0);
        tick();
        chk("to_err_hold", {31'd0, bus.err}, 32'd1);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h300;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12345678;
        tick();
        chk("nx_gnt0", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        bus.req0 = 1'b0;
        tick();
        chk("nx_done0", {30'd0, bus.done1, bus.done0}, 32'd1);
        chk("nx_err", {31'd0, bus.err}, 32'd0);
        chk("nx_rdata", bus.rdata, 32'h12345678);
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        tick();

        // Reset during the second ACCESS cycle of a write
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h400; bus.wdata0 = 32'hDEADBEEF;
        tick();
        chk("ra_gnt0", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        chk("ra_write1", {31'd0, bus.mem_write}, 32'd1);
        tick();
        chk("ra_write2", {31'd0, bus.mem_write}, 32'd1);
        reset = 1'b0;
        #1;
        chk("ra_write_drop", {31'd0, bus.mem_write}, 32'd0);
        chk("ra_addr_drop", bus.mem_addr, 32'd0);
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h600;
        tick();
        chk("ra_no_done", {30'd0, bus.done1, bus.done0}, 32'd0);
        reset = 1'b1;
        tick();
        chk("ra_arm", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        chk("ra_no_done2", {30'd0, bus.done1, bus.done0}, 32'd0);
        tick();
        chk("ra_tie_gnt0", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        bus.mem_ready = 1'b1;
        tick();
        chk("ra_done0", {30'd0, bus.done1, bus.done0}, 32'd1);
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.mem_ready = 1'b0;
        tick();

        // Request withdrawal and address change after grant
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h500;
        tick();
        chk("wd_gnt0", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        tick();
        bus.req0 = 1'b0; bus.addr0 = 32'h999;
        tick();
        chk("wd_addr_kept", bus.mem_addr, 32'h500);
        chk("wd_read", {31'd0, bus.mem_read}, 32'd1);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA5A5A5A5;
        tick();
        chk("wd_done0", {30'd0, bus.done1, bus.done0}, 32'd1);
        chk("wd_rdata", bus.rdata, 32'hA5A5A5A5);
        bus.mem_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.gnt0 || bus.gnt1) n++;
        end
        chk("wd_no_regrant", n, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk (rising-edge) and reset (asynchronous, active-low).
REQ-002 Ports SHALL be:
- clk  in  1  system clock
- reset  in  1  async active-low reset
- req0, req1  in  1 each  access request; req0 is the control unit (fetch/load/store), req1 is the loader/debug port
- we0, we1  in  1 each  1 = write, 0 = read
- addr0, addr1  in  32 each  byte address
- wdata0, wdata1  in  32 each  write data
- gnt0, gnt1  out  1 each  one-cycle grant pulse
- done0, done1  out  1 each  one-cycle completion pulse
- err  out  1  valid with done; 1 = timeout
- rdata  out  32  read data, valid with done
- mem_read, mem_write  out  1 each  memory strobes
- mem_addr, mem_wdata  out  32 each  memory address and write data
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory completes the access this cycle

Function
REQ-003 The state machine SHALL have three states: IDLE, ACCESS and RESP.
REQ-004 In IDLE with at least one reqN high, the next edge SHALL latch the winner's we, addr and wdata, set the active owner and go to ACCESS.
REQ-005 gntN SHALL be high for exactly the first ACCESS cycle.
REQ-006 Arbitration SHALL be round-robin.
- When both requesters are requesting, the one not granted most recently wins.
- Requester 0 wins the first tie after reset.
- A lone requester always wins.
REQ-007 The last-granted pointer SHALL update only on a grant.
REQ-008 In ACCESS, mem_read (we=0) or mem_write (we=1) SHALL be high every cycle, and mem_addr and mem_wdata SHALL equal the latched values.
- Strobes, mem_addr and mem_wdata SHALL NOT change while in ACCESS.
REQ-009 Outside ACCESS, mem_read, mem_write, mem_addr and mem_wdata SHALL be 0.
REQ-010 mem_ready SHALL be sampled only in ACCESS; it is ignored in IDLE and RESP.
REQ-011 mem_ready high at an ACCESS edge SHALL move the block to RESP and capture rdata = mem_rdata (reads) or 0 (writes), with err = 0.
- mem_ready high on the first ACCESS cycle is legal.
REQ-012 A 4-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ready.
- When the counter reaches 15 without mem_ready, the next edge SHALL go to RESP with err = 1 and rdata = 0.
- Maximum ACCESS length is 16 cycles.
REQ-013 In RESP, done of the owner SHALL be high for exactly one cycle with rdata and err valid; the next state is IDLE.
REQ-014 rdata and err SHALL hold their value until the next RESP.
REQ-015 Latency SHALL be:
- req sampled at edge k gives gnt in cycle k+1;
- with mem_ready sampled at edge k+1+w, done is in cycle k+2+w.
- Minimum request-to-done is 2 cycles.
- The back-to-back issue interval is at least 3 cycles (IDLE bubble).
REQ-016 reqN deasserted after grant SHALL NOT abort the access; done still pulses.
REQ-017 Changes to addrN, wdataN or weN after grant SHALL have no effect.
REQ-018 gnt0 and gnt1 SHALL never both be high, done0 and done1 SHALL never both be high, and mem_read and mem_write SHALL never both be high.

Reset
REQ-019 reset low SHALL immediately, without waiting for clk, force:
- state = IDLE;
- all gnt, done, err and mem strobes = 0;
- rdata, mem_addr and mem_wdata = 0;
- wait counter = 0;
- pointer so that requester 0 wins the next tie.
REQ-020 Reset asserted during ACCESS SHALL drop strobes immediately and produce no done for the aborted access.
REQ-021 The first grant SHALL occur no earlier than the second rising edge after reset deasserts.

Verification
REQ-022 Single read: req0=1, we0=0, addr0=0x100; memory asserts mem_ready on the 3rd ACCESS cycle with mem_rdata=0xCAFEF00D -> mem_read high 3 cycles, mem_addr=0x100, done0 pulse with rdata=0xCAFEF00D, err=0.
REQ-023 Contention: req0 and req1 held high continuously, mem_ready=1 always, both we=1 -> grants alternate 0,1,0,1; first grant to requester 0; every mem_write pulse carries the matching addr/wdata.
REQ-024 Timeout: req1 read at addr1=0x2000 with mem_ready tied 0 -> mem_read high exactly 16 cycles, then done1 with err=1, rdata=0; the next access completes normally with err=0.
REQ-025 Reset mid-access: reset low during the 2nd ACCESS cycle of a write -> mem_write=0 immediately, no done; after release req1 with req0 also high -> requester 0 granted first.
REQ-026 Request withdrawal: req0 dropped and addr0 changed to 0x999 one cycle after gnt0 -> access completes at the original address, done0 pulses, no new grant follows.
